// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared UART definitions: receiver FSM states, received-frame payload,
// and the divider/parity helpers also used by the transmitter.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_e;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 parity_error;
    logic                 stop_error;
  } rx_frame_t;

  // Clocks per oversample tick, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk_hz / (baud * os);
  endfunction

  // Expected parity bit for a data word.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                       input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
// Oversample tick generator: free-running 0..DIV-1 counter with a
// synchronous phase restart and a registered one-cycle tick at DIV-1.
module uart_baud_tick #(
  parameter int unsigned DIV = 325
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (restart || (cnt == CNT_LAST)) begin
      cnt_nxt = '0;
    end
  end

  // tick is registered so it is high exactly while cnt sits at DIV-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == CNT_LAST);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
`timescale 1ns/1ps
// Oversampling UART receiver: 2-FF synchronized line, 3-sample majority
// per bit, optional parity, valid/ready holding register with overrun pulse.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_rx,
  output logic                 parity_error,
  output logic                 stop_error,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned SC_W = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W = $clog2(DATA_BITS);

  localparam logic [SC_W-1:0] SC_A    = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_B    = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_BITS - 1);
  localparam logic            PAR_ODD  = 1'(PARITY_ODD);

  logic rxd_m;
  logic rxd_s;
  logic tick;

  rx_state_e state;
  rx_state_e state_nxt;

  logic [SC_W-1:0]      sc;
  logic [BC_W-1:0]      bit_cnt;
  logic                 samp_a;
  logic                 samp_b;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err;
  logic                 stop_err;
  logic                 frame_done;

  logic      mid_c;
  logic      wrap_c;
  logic      maj_c;
  logic      restart_c;
  logic      shift_en_c;
  logic      bit_adv_c;
  logic      par_chk_c;
  logic      stop_chk_c;
  rx_frame_t frame_c;

  // Line synchronizer; idles high out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk     (clk),
    .rst_n   (reset),
    .restart (restart_c),
    .tick    (tick)
  );

  assign mid_c   = tick && (sc == SC_MID);
  assign wrap_c  = tick && (sc == SC_LAST);
  assign maj_c   = (samp_a & samp_b) | (samp_a & rxd_s) | (samp_b & rxd_s);
  assign frame_c = {shift, par_err, stop_err};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (!rxd_s) state_nxt = START;
      START: begin
        if (mid_c && maj_c) begin
          state_nxt = IDLE;
        end else if (wrap_c) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (wrap_c && (bit_cnt == BIT_LAST)) begin
          state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY:     if (wrap_c) state_nxt = STOP;
      STOP:       if (mid_c) state_nxt = maj_c ? IDLE : BREAK_WAIT;
      BREAK_WAIT: if (tick && rxd_s) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    restart_c  = 1'b0;
    shift_en_c = 1'b0;
    bit_adv_c  = 1'b0;
    par_chk_c  = 1'b0;
    stop_chk_c = 1'b0;
    case (state)
      IDLE:    restart_c = !rxd_s;
      DATA: begin
        shift_en_c = mid_c;
        bit_adv_c  = wrap_c;
      end
      PARITY:  par_chk_c  = mid_c;
      STOP:    stop_chk_c = mid_c;
      default: ;
    endcase
  end

  // Bit timing, majority samples and frame assembly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sc         <= '0;
      bit_cnt    <= '0;
      samp_a     <= 1'b1;
      samp_b     <= 1'b1;
      shift      <= '0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= stop_chk_c;
      if (restart_c) begin
        sc       <= '0;
        bit_cnt  <= '0;
        par_err  <= 1'b0;
        stop_err <= 1'b0;
      end else if (tick) begin
        sc <= (sc == SC_LAST) ? '0 : sc + SC_W'(1);
      end
      if (tick && (sc == SC_A)) samp_a <= rxd_s;
      if (tick && (sc == SC_B)) samp_b <= rxd_s;
      if (shift_en_c) shift <= {maj_c, shift[DATA_BITS-1:1]};
      if (bit_adv_c) bit_cnt <= bit_cnt + BC_W'(1);
      if (par_chk_c) par_err <= maj_c ^ calc_parity(shift, PAR_ODD);
      if (stop_chk_c) stop_err <= !maj_c;
    end
  end

  // Holding register: a completed frame loads only when the slot is free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out     <= '0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      valid_rx     <= 1'b0;
      overrun      <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      rx_busy <= (state_nxt != IDLE);
      if (frame_done) begin
        if (!valid_rx || rx_ready) begin
          {data_out, parity_error, stop_error} <= frame_c;
          valid_rx <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid_rx && rx_ready) begin
        valid_rx <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx_os: vector table, hand-written corner
// sequences and random frames against a frame-level reference model.
module tb_uart_rx_os;

  localparam int unsigned CLK_FREQ = 1280000;
  localparam int unsigned BAUD     = 10000;
  localparam int unsigned OS       = 16;
  localparam int unsigned DIV      = CLK_FREQ / (BAUD * OS);
  localparam int unsigned BIT_CLKS = DIV * OS;
  // start edge -> 2 sync flops + detect, then DIV per tick up to stop-bit
  // sample OS/2+1, then one registered stage into valid_rx
  localparam int EXP_LAT = 3 + int'(DIV * (10 * OS + OS / 2 + 2)) + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] data_out;
  logic       valid_rx;
  logic       parity_error;
  logic       stop_error;
  logic       overrun;
  logic       rx_busy;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  rise_cnt = 0;
  int  ovr_cnt  = 0;
  time rise_time = 0;
  logic valid_d = 1'b0;

  always #5 clk = ~clk;

  uart_rx_os #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .PARITY_EN  (1),
    .PARITY_ODD (0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rxd          (rxd),
    .rx_ready     (rx_ready),
    .data_out     (data_out),
    .valid_rx     (valid_rx),
    .parity_error (parity_error),
    .stop_error   (stop_error),
    .overrun      (overrun),
    .rx_busy      (rx_busy)
  );

  always @(negedge clk) begin
    if (valid_rx && !valid_d) begin
      rise_cnt  <= rise_cnt + 1;
      rise_time <= $time;
    end
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    valid_d <= valid_rx;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // line bits, index 0 sent first: start, data LSB-first, even parity, stop
  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic flip, input logic stop);
    return {stop, (^d) ^ flip, d, 1'b0};
  endfunction

  // reference decode of a transmitted bit list: {data, parity_error, stop_error}
  function automatic logic [9:0] model(input logic [10:0] bits);
    logic [7:0] d;
    logic       pe;
    logic       se;
    d  = bits[8:1];
    pe = ^bits[9:1];
    se = ~bits[10];
    return {d, pe, se};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int unsigned clks);
    for (int i = 0; i < 11; i++) begin
      rxd = bits[i];
      repeat (clks) @(negedge clk);
    end
  endtask

  task automatic wait_valid(input string name, input int unsigned bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(bound); i++) begin
      if (valid_rx) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL %s valid_rx: timeout after %0d cycles", name, bound);
    end
  endtask

  task automatic ack(input string name);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    #1;
    check({name, " drop"}, 32'(valid_rx), 32'(0));
  endtask

  task automatic do_frame(input string name, input logic [10:0] bits, input int unsigned clks,
                          input logic [7:0] ed, input logic epe, input logic ese);
    int  r0;
    int  lat;
    time t0;
    bit  ok;
    @(negedge clk);
    r0 = rise_cnt;
    t0 = $time;
    send_bits(bits, clks);
    rxd = 1'b1;
    wait_valid(name, 4 * BIT_CLKS, ok);
    #1;
    if (ok) begin
      lat = int'((rise_time - t0) / 10);
      check({name, " data"}, 32'(data_out), 32'(ed));
      check({name, " parity_error"}, 32'(parity_error), 32'(epe));
      check({name, " stop_error"}, 32'(stop_error), 32'(ese));
      check({name, " valid count"}, 32'(rise_cnt - r0), 32'(1));
      check({name, " latency"}, 32'((lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1) ? EXP_LAT : lat),
            32'(EXP_LAT));
      ack(name);
    end
    repeat (2 * clks) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  d;
    logic        flip;
    logic        stop;
    int unsigned clks;
    logic [7:0]  ed;
    logic        epe;
    logic        ese;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  r0;
    int  o0;
    bit  ok;
    logic [10:0] bits;
    logic [9:0]  exp_f;

    reset    = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset data_out", 32'(data_out), 32'(0));
    check("reset valid_rx", 32'(valid_rx), 32'(0));
    check("reset parity_error", 32'(parity_error), 32'(0));
    check("reset stop_error", 32'(stop_error), 32'(0));
    check("reset overrun", 32'(overrun), 32'(0));
    check("reset rx_busy", 32'(rx_busy), 32'(0));
    reset = 1'b1;
    repeat (20) @(negedge clk);

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 128, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 128, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'hC3, 1'b0, 1'b1, 124, 8'hC3, 1'b0, 1'b0};
    vecs[3] = '{8'hC3, 1'b0, 1'b1, 132, 8'hC3, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 128, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 128, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 128, 8'h80, 1'b1, 1'b0};
    vecs[7] = '{8'h5A, 1'b0, 1'b0, 128, 8'h5A, 1'b0, 1'b1};
    vecs[8] = '{8'h7E, 1'b1, 1'b0, 128, 8'h7E, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      do_frame($sformatf("vec%0d", i), make_frame(vecs[i].d, vecs[i].flip, vecs[i].stop),
               vecs[i].clks, vecs[i].ed, vecs[i].epe, vecs[i].ese);
    end

    // break: bad stop bit then line held low for 3 more bit times
    @(negedge clk);
    r0 = rise_cnt;
    send_bits(make_frame(8'h3C, 1'b0, 1'b0), BIT_CLKS);
    repeat (3 * BIT_CLKS) @(negedge clk);
    check("break valid", 32'(valid_rx), 32'(1));
    check("break data", 32'(data_out), 32'(8'h3C));
    check("break stop_error", 32'(stop_error), 32'(1));
    check("break parity_error", 32'(parity_error), 32'(0));
    check("break busy while low", 32'(rx_busy), 32'(1));
    ack("break");
    rxd = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("break busy after high", 32'(rx_busy), 32'(0));
    check("break valid count", 32'(rise_cnt - r0), 32'(1));
    do_frame("after break", make_frame(8'h55, 1'b0, 1'b1), BIT_CLKS, 8'h55, 1'b0, 1'b0);

    // glitch: 3 sample ticks low on an idle line
    @(negedge clk);
    r0  = rise_cnt;
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch busy", 32'(rx_busy), 32'(1));
    repeat (3 * DIV - 20) @(negedge clk);
    rxd = 1'b1;
    repeat (90 - 3 * DIV) @(negedge clk);
    check("glitch busy cleared", 32'(rx_busy), 32'(0));
    repeat (BIT_CLKS) @(negedge clk);
    check("glitch no valid", 32'(rise_cnt - r0), 32'(0));
    do_frame("after glitch", make_frame(8'hFF, 1'b0, 1'b1), BIT_CLKS, 8'hFF, 1'b0, 1'b0);

    // overrun: two back-to-back frames with the consumer stalled
    @(negedge clk);
    r0 = rise_cnt;
    o0 = ovr_cnt;
    send_bits(make_frame(8'h11, 1'b0, 1'b1), BIT_CLKS);
    send_bits(make_frame(8'h22, 1'b0, 1'b1), BIT_CLKS);
    rxd = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("overrun valid", 32'(valid_rx), 32'(1));
    check("overrun data kept", 32'(data_out), 32'(8'h11));
    check("overrun pulses", 32'(ovr_cnt - o0), 32'(1));
    check("overrun valid count", 32'(rise_cnt - r0), 32'(1));
    ack("overrun");

    // reset mid-DATA with a byte still held
    @(negedge clk);
    send_bits(make_frame(8'h96, 1'b0, 1'b1), BIT_CLKS);
    rxd = 1'b1;
    wait_valid("pre-reset", 4 * BIT_CLKS, ok);
    #1;
    check("pre-reset data", 32'(data_out), 32'(8'h96));
    @(negedge clk);
    r0 = rise_cnt;
    fork
      send_bits(make_frame(8'h3A, 1'b0, 1'b1), BIT_CLKS);
      begin
        repeat (4 * BIT_CLKS) @(negedge clk);
        #1;
        check("mid-frame busy", 32'(rx_busy), 32'(1));
        #1;
        reset = 1'b0;
        #1;
        check("reset data_out", 32'(data_out), 32'(0));
        check("reset valid", 32'(valid_rx), 32'(0));
        check("reset busy", 32'(rx_busy), 32'(0));
      end
    join
    rxd = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("aborted frame no valid", 32'(rise_cnt - r0), 32'(0));
    do_frame("after reset", make_frame(8'hE7, 1'b0, 1'b1), BIT_CLKS, 8'hE7, 1'b0, 1'b0);

    // random frames against the reference decode
    for (int k = 0; k < 12; k++) begin
      bits  = make_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) != 0));
      exp_f = model(bits);
      do_frame($sformatf("rand%0d", k), bits, $urandom_range(124, 132),
               exp_f[9:2], exp_f[1], exp_f[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
